bsg_sipo_frame_extractor: RTL and testbench
===========================================

Name: bsg_sipo_frame_extractor

Overview:
- Downstream consumer of a serial-in-parallel-out buffer.
- Inspects the buffer's parallel window of up to els_p valid words and locates a header word.
- Once header plus payload are fully present, captures the whole frame into a one-entry output register and dequeues it with a multi-word yumi count.
- Malformed headers are discarded one word at a time and counted.

Parameters:
- width_p, 16, word width in bits; header format described below.
- els_p, 4, window size (equals upstream out_els_p); power of two, ≥2.
- len_width_p, $clog2(els_p), width of the header length field.
- drop_width_p, 8, width of the saturating drop counter.
- timeout_p, 15, stall cycles before abandoning an incomplete frame; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous reset, active-high.
- valid_i  in  els_p  window valid bits; only a contiguous prefix from bit 0 may be set.
- data_i  in  els_p*width_p  window words; word 0 is the oldest.
- yumi_cnt_o  out  $clog2(els_p+1)  number of window words consumed this cycle.
- v_o  out  1  output frame valid.
- data_o  out  els_p*width_p  frame payload words; unused slots are zero.
- len_o  out  len_width_p  payload length L of the held frame.
- ready_i  in  1  downstream accepts the frame when v_o&ready_i.
- drop_cnt_o  out  drop_width_p  saturating count of discarded words.

Behaviour:
- Header word: bit width_p-1 is SOF and must be 1; bits [len_width_p-1:0] give L in 0..els_p-1. The frame is the header plus L payload words.
- Output slot states:
  - EMPTY: v_o=0.
  - FULL: v_o=1.
  - slot_free = EMPTY | (v_o&ready_i).
- Each cycle, evaluate window word 0 in this priority order:
  - valid_i[0]=0: yumi_cnt_o=0.
  - valid_i[0]=1 and SOF=0: yumi_cnt_o=1. drop_cnt_o increments by 1, saturating at all-ones. Does not require slot_free.
  - SOF=1, valid_i[L]=1, slot_free: yumi_cnt_o=L+1. Next cycle state is FULL with data_o[i]=data_i[i+1] for i<L and 0 otherwise, and len_o=L.
  - SOF=1 and frame incomplete or !slot_free: yumi_cnt_o=0 (stall).
- If v_o&ready_i and no capture occurs, the next state is EMPTY.
- Capture and dequeue in the same cycle sustain one frame per cycle.
- Latency: a complete frame in the window appears on v_o the next cycle.
- yumi_cnt_o is combinational from valid_i, data_i, ready_i and state. It must never exceed the number of set valid_i bits.
- v_o does not depend combinationally on ready_i.
- At most one frame or one dropped word is consumed per cycle.
- Reset: v_o=0, len_o=0, data_o=0, drop_cnt_o=0, yumi_cnt_o=0 while reset_i=1. A frame held at reset is lost. The upstream buffer is reset on the same reset.
- L=0 is legal: a header-only frame with yumi_cnt_o=1 and all data_o slots zero.

Optional Feature:
- BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN defined:
  - A stall counter increments on each cycle the SOF=1 header is valid but the frame is incomplete.
  - It clears on any consume, on valid_i[0]=0, or on reset.
  - It does not count while stalled only on !slot_free.
  - When the counter reaches timeout_p, that cycle drops the header: yumi_cnt_o=1, drop_cnt_o+1, counter clears.
- Undefined: no counter; an incomplete frame waits indefinitely.

Decomposition:
- Shared package bsg_sipo_frame_pkg holds:
  - the header field constants (SOF bit position, length field LSB);
  - an enum for the slot state {eEmpty, eFull};
  - a packed header struct parameterized by width via a localparam.
- One natural sub-module: bsg_sipo_frame_decode, purely combinational. It produces SOF, L, frame_complete and the shifted payload from the window.

Test Plan:
- Aligned frames: width_p=16, els_p=4, window {0x8002,0x1111,0x2222} valid 3'b111, ready_i=1 -> yumi_cnt_o=3; next cycle v_o=1, len_o=2, data_o={0,0,0x2222,0x1111}.
- Malformed header: window word0=0x0005, valid=1 -> yumi_cnt_o=1, drop_cnt_o 0→1. Holding 256 such words with drop_width_p=8 -> drop_cnt_o stays at 0xFF.
- Partial then complete: header 0x8003 with valid=4'b0011 -> yumi 0 for 5 cycles; valid becomes 4'b1111 -> yumi 4, frame out next cycle.
- Backpressure: frame held, ready_i=0, next complete frame present -> yumi 0. Raise ready_i -> same-cycle dequeue and capture, v_o stays 1 with the new frame.
- Timeout (macro on, timeout_p=15): header 0x8003 with valid=4'b0001 held -> at stall cycle 15 yumi 1 and drop_cnt_o+1. Macro off -> yumi stays 0 for 100 cycles.
- Reset mid-frame: v_o=1, assert reset_i one cycle -> v_o=0, drop_cnt_o=0, yumi_cnt_o=0 during reset.

Source files
------------

// File: rtl/bsg_sipo_frame_pkg.sv
// Shared definitions for the SIPO frame extractor: header field positions and slot state.
package bsg_sipo_frame_pkg;

    localparam int hdr_width_lp = 16;
    localparam int len_lsb_lp   = 0;

    typedef enum logic {
        eEmpty,
        eFull
    } slot_state_e;

    typedef struct packed {
        logic                    sof;
        logic [hdr_width_lp-2:0] body;
    } frame_hdr_s;

    // SOF always sits in the MSB of a header word, whatever the word width.
    function automatic int sof_pos(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/bsg_sipo_frame_decode.sv
// Combinational header decode of the SIPO window: SOF, payload length, completeness
// and the payload shifted down past the header word.
module bsg_sipo_frame_decode
    import bsg_sipo_frame_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int els_p       = 4,
    parameter int len_width_p = $clog2(els_p)
) (
    input  logic [els_p-1:0]         valid,
    input  logic [els_p*width_p-1:0] data,
    output logic                     sof,
    output logic [len_width_p-1:0]   len,
    output logic                     complete,
    output logic [els_p*width_p-1:0] payload
);

    localparam int sof_lp = sof_pos(width_p);

    logic unused_hdr_bits;

    assign sof             = data[sof_lp];
    assign len             = data[len_lsb_lp +: len_width_p];
    assign unused_hdr_bits = ^data[sof_lp-1:len_width_p];

    // Valid bits form a prefix, so the word at index L being valid means all L payload words are present.
    assign complete = valid[len];

    always_comb begin
        payload = '0;
        for (int i = 0; i < els_p - 1; i++) begin
            if (i < int'(len)) begin
                payload[i*width_p +: width_p] = data[(i+1)*width_p +: width_p];
            end
        end
    end

endmodule

// File: rtl/bsg_sipo_frame_extractor.sv
// Extracts header-delimited frames from a SIPO window into a one-entry output slot.
// Optional stall timeout enabled by defining BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN.
module bsg_sipo_frame_extractor
    import bsg_sipo_frame_pkg::*;
#(
    parameter int width_p      = 16,
    parameter int els_p        = 4,
    parameter int len_width_p  = $clog2(els_p),
    parameter int drop_width_p = 8,
    parameter int timeout_p    = 15
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [els_p-1:0]               valid_i,
    input  logic [els_p*width_p-1:0]       data_i,
    output logic [$clog2(els_p+1)-1:0]     yumi_cnt_o,
    output logic                           v_o,
    output logic [els_p*width_p-1:0]       data_o,
    output logic [len_width_p-1:0]         len_o,
    input  logic                           ready_i,
    output logic [drop_width_p-1:0]        drop_cnt_o
);

    localparam int yumi_width_lp = $clog2(els_p + 1);

    slot_state_e                 state_r, state_n;
    logic [els_p*width_p-1:0]    data_r;
    logic [len_width_p-1:0]      len_r;
    logic [drop_width_p-1:0]     drop_r;

    logic                        sof;
    logic [len_width_p-1:0]      len;
    logic                        complete;
    logic [els_p*width_p-1:0]    payload;

    logic                        slot_free;
    logic                        capture;
    logic                        drop;
    logic [yumi_width_lp-1:0]    yumi;

`ifdef BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN
    localparam int stall_width_lp = $clog2(timeout_p + 1);
    logic [stall_width_lp-1:0]   stall_r, stall_n;
`endif

    bsg_sipo_frame_decode #(
        .width_p    (width_p),
        .els_p      (els_p),
        .len_width_p(len_width_p)
    ) decode (
        .valid   (valid_i),
        .data    (data_i),
        .sof     (sof),
        .len     (len),
        .complete(complete),
        .payload (payload)
    );

    assign slot_free = (state_r == eEmpty) || ready_i;

    always_comb begin
        yumi    = '0;
        capture = 1'b0;
        drop    = 1'b0;
        state_n = state_r;
`ifdef BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN
        stall_n = stall_r;
`endif
        if (state_r == eFull && ready_i) begin
            state_n = eEmpty;
        end
        if (valid_i[0]) begin
            if (!sof) begin
                yumi = yumi_width_lp'(1);
                drop = 1'b1;
            end else if (complete && slot_free) begin
                yumi    = yumi_width_lp'(len) + yumi_width_lp'(1);
                capture = 1'b1;
                state_n = eFull;
            end
`ifdef BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN
            // A complete frame blocked only by the slot keeps its stall count unchanged.
            else if (!complete) begin
                if (stall_r == stall_width_lp'(timeout_p - 1)) begin
                    yumi = yumi_width_lp'(1);
                    drop = 1'b1;
                end else begin
                    stall_n = stall_r + stall_width_lp'(1);
                end
            end
`endif
        end
`ifdef BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN
        if (!valid_i[0] || capture || drop) begin
            stall_n = '0;
        end
`endif
        if (reset_i) begin
            yumi = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eEmpty;
            data_r  <= '0;
            len_r   <= '0;
            drop_r  <= '0;
`ifdef BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN
            stall_r <= '0;
`endif
        end else begin
            state_r <= state_n;
            if (capture) begin
                data_r <= payload;
                len_r  <= len;
            end
            if (drop && (drop_r != '1)) begin
                drop_r <= drop_r + drop_width_p'(1);
            end
`ifdef BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN
            stall_r <= stall_n;
`endif
        end
    end

    assign yumi_cnt_o = yumi;
    assign v_o        = (state_r == eFull);
    assign data_o     = data_r;
    assign len_o      = len_r;
    assign drop_cnt_o = drop_r;

endmodule

// File: tb/tb_bsg_sipo_frame_extractor.sv
// Self-checking bench for bsg_sipo_frame_extractor against a queue-based reference of the upstream buffer.
module tb_bsg_sipo_frame_extractor;

    localparam int W  = 16;
    localparam int E  = 4;
    localparam int LW = 2;
    localparam int YW = 3;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [E-1:0]  valid_i;
    logic [E*W-1:0] data_i;
    logic [YW-1:0] yumi_cnt_o;
    logic          v_o;
    logic [E*W-1:0] data_o;
    logic [LW-1:0] len_o;
    logic          ready_i;
    logic [DW-1:0] drop_cnt_o;

    always #5 clk_i = ~clk_i;

    bsg_sipo_frame_extractor #(
        .width_p     (W),
        .els_p       (E),
        .len_width_p (LW),
        .drop_width_p(DW),
        .timeout_p   (TO)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .yumi_cnt_o(yumi_cnt_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .len_o     (len_o),
        .ready_i   (ready_i),
        .drop_cnt_o(drop_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Upstream buffer contents (oldest first) and the reference view of the output slot.
    logic [W-1:0] q[$];
    logic [W-1:0] pend[$];
    bit           m_v;
    int           m_len;
    logic [W-1:0] m_data[E];
    int           m_drop;
    int           m_wait;

    task automatic drive();
        valid_i = '0;
        data_i  = '0;
        for (int i = 0; i < E; i++) begin
            if (i < q.size()) begin
                valid_i[i]       = 1'b1;
                data_i[i*W +: W] = q[i];
            end
        end
    endtask

    task automatic step(input string tag);
        int           n;
        int           exp_y;
        int           hl;
        bit           take;
        bit           drp;
        logic [W-1:0] h;
        logic [E*W-1:0] ed;
        drive();
        #1;
        n     = (q.size() < E) ? q.size() : E;
        exp_y = 0;
        hl    = 0;
        take  = 0;
        drp   = 0;
        if (n == 0) begin
            m_wait = 0;
        end else begin
            h = q[0];
            if (!h[W-1]) begin
                exp_y = 1;
                drp   = 1;
            end else begin
                hl = int'(h[LW-1:0]);
                if (n > hl && (!m_v || ready_i)) begin
                    exp_y = hl + 1;
                    take  = 1;
                end else if (n <= hl) begin
`ifdef BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN
                    m_wait++;
                    if (m_wait >= TO) begin
                        exp_y = 1;
                        drp   = 1;
                    end
`endif
                end
            end
        end
        if (exp_y != 0) m_wait = 0;
        n_checks++;
        if (yumi_cnt_o !== YW'(exp_y)) begin
            n_fail++;
            $display("FAIL %s yumi_cnt: got %0d expected %0d", tag, yumi_cnt_o, exp_y);
        end
        @(posedge clk_i);
        #1;
        if (take) begin
            m_v   = 1;
            m_len = hl;
            for (int i = 0; i < E; i++) begin
                m_data[i] = '0;
                if (i < hl) m_data[i] = q[i+1];
            end
        end else if (m_v && ready_i) begin
            m_v = 0;
        end
        if (drp && m_drop < 255) m_drop++;
        repeat (exp_y) void'(q.pop_front());
        n_checks++;
        if (v_o !== m_v) begin
            n_fail++;
            $display("FAIL %s v_o: got %0b expected %0b", tag, v_o, m_v);
        end
        n_checks++;
        if (drop_cnt_o !== DW'(m_drop)) begin
            n_fail++;
            $display("FAIL %s drop_cnt: got %0d expected %0d", tag, drop_cnt_o, m_drop);
        end
        if (m_v) begin
            for (int i = 0; i < E; i++) ed[i*W +: W] = m_data[i];
            n_checks++;
            if (len_o !== LW'(m_len) || data_o !== ed) begin
                n_fail++;
                $display("FAIL %s frame: got len %0d data %h expected len %0d data %h",
                         tag, len_o, data_o, m_len, ed);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        reset_i = 1'b1;
        valid_i = 4'b0111;
        data_i  = {16'h0000, 16'h2222, 16'h1111, 16'h8002};
        #1;
        n_checks++;
        if (yumi_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL %s reset_yumi: got %0d expected 0", tag, yumi_cnt_o);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if (v_o !== 1'b0 || len_o !== '0 || data_o !== '0 || drop_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL %s reset_state: got v %0b len %0d data %h drop %0d expected all zero",
                     tag, v_o, len_o, data_o, drop_cnt_o);
        end
        reset_i = 1'b0;
        q.delete();
        pend.delete();
        m_v    = 0;
        m_len  = 0;
        m_drop = 0;
        m_wait = 0;
    endtask

    task automatic test_reset();
        ready_i = 1'b1;
        do_reset("reset");
    endtask

    task automatic test_aligned();
        ready_i = 1'b1;
        q = '{16'h8002, 16'h1111, 16'h2222};
        step("aligned");
        n_checks++;
        if (v_o !== 1'b1 || len_o !== 2'd2 || data_o !== 64'h0000_0000_2222_1111) begin
            n_fail++;
            $display("FAIL aligned_out: got v %0b len %0d data %h expected 1 2 0000000022221111",
                     v_o, len_o, data_o);
        end
        step("aligned_drain");
    endtask

    task automatic test_header_only();
        q = '{16'h8000};
        step("len0");
        n_checks++;
        if (v_o !== 1'b1 || len_o !== 2'd0 || data_o !== '0) begin
            n_fail++;
            $display("FAIL len0_out: got v %0b len %0d data %h expected 1 0 0", v_o, len_o, data_o);
        end
        step("len0_drain");
    endtask

    task automatic test_malformed();
        q = '{16'h0005};
        step("malformed");
        n_checks++;
        if (drop_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL malformed_cnt: got %0d expected 1", drop_cnt_o);
        end
        for (int i = 0; i < 300; i++) q.push_back(16'h0005);
        for (int i = 0; i < 300; i++) step("saturate");
        n_checks++;
        if (drop_cnt_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturate_cnt: got %0d expected 255", drop_cnt_o);
        end
        do_reset("after_saturate");
    endtask

    task automatic test_partial();
        ready_i = 1'b1;
        q = '{16'h8003, 16'h0001};
        for (int i = 0; i < 5; i++) step("partial_wait");
        q.push_back(16'h0002);
        q.push_back(16'h0003);
        step("partial_done");
        n_checks++;
        if (v_o !== 1'b1 || len_o !== 2'd3 || data_o !== 64'h0000_0003_0002_0001) begin
            n_fail++;
            $display("FAIL partial_out: got v %0b len %0d data %h expected 1 3 0000000300020001",
                     v_o, len_o, data_o);
        end
        step("partial_drain");
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        q = '{16'h8001, 16'haaaa};
        step("bp_first");
        ready_i = 1'b0;
        q.push_back(16'h8002);
        q.push_back(16'hbbbb);
        q.push_back(16'hcccc);
        for (int i = 0; i < 3; i++) step("bp_hold");
        ready_i = 1'b1;
        step("bp_release");
        n_checks++;
        if (v_o !== 1'b1 || len_o !== 2'd2 || data_o !== 64'h0000_0000_cccc_bbbb) begin
            n_fail++;
            $display("FAIL bp_out: got v %0b len %0d data %h expected 1 2 00000000ccccbbbb",
                     v_o, len_o, data_o);
        end
        step("bp_drain");
    endtask

    task automatic test_timeout();
        do_reset("pre_timeout");
        ready_i = 1'b1;
        q = '{16'h8003};
`ifdef BSG_SIPO_FRAME_EXTRACTOR_TIMEOUT_EN
        for (int i = 0; i < 20; i++) step("timeout");
        n_checks++;
        if (drop_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL timeout_cnt: got %0d expected 1", drop_cnt_o);
        end
`else
        for (int i = 0; i < 100; i++) step("no_timeout");
        n_checks++;
        if (drop_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL no_timeout_cnt: got %0d expected 0", drop_cnt_o);
        end
`endif
        do_reset("post_timeout");
    endtask

    task automatic test_reset_midframe();
        ready_i = 1'b0;
        q = '{16'h8001, 16'h1234};
        step("mid_load");
        do_reset("mid_reset");
        ready_i = 1'b1;
    endtask

    task automatic test_random();
        int l;
        for (int c = 0; c < 500; c++) begin
            if (pend.size() == 0) begin
                if ($urandom_range(0, 4) == 0) begin
                    pend.push_back(W'($urandom_range(0, 16'h7fff)));
                end else begin
                    l = $urandom_range(0, E-1);
                    pend.push_back({1'b1, 13'($urandom), LW'(l)});
                    for (int i = 0; i < l; i++) pend.push_back(W'($urandom));
                end
            end
            repeat ($urandom_range(0, 2)) begin
                if (q.size() < E && pend.size() > 0) q.push_back(pend.pop_front());
            end
            ready_i = ($urandom_range(0, 3) != 0);
            step("random");
        end
    endtask

    initial begin
        reset_i = 1'b1;
        ready_i = 1'b1;
        valid_i = '0;
        data_i  = '0;
        test_reset();
        test_aligned();
        test_header_only();
        test_malformed();
        test_partial();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
